// File: rtl/xge_pkt_gen.sv
// Deterministic Ethernet frame source for the 10G MAC transmit interface.
// Emits numbered frames with configurable length, count and gap.
module xge_pkt_gen #(
    parameter logic [47:0] DST_MAC   = 48'hFFFFFFFFFFFF,
    parameter logic [47:0] SRC_MAC   = 48'h000A35000001,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int          MIN_LEN   = 60,
    parameter int          MAX_LEN   = 9596
) (
    input  logic        clk_156,
    input  logic        reset_156,
    input  logic        start,
    input  logic        stop,
    input  logic [13:0] cfg_len,
    input  logic [31:0] cfg_num_pkts,
    input  logic [7:0]  cfg_ipg,
    input  logic        pkt_tx_full,
    output logic [63:0] pkt_tx_data,
    output logic        pkt_tx_sop,
    output logic        pkt_tx_eop,
    output logic [2:0]  pkt_tx_mod,
    output logic        pkt_tx_val,
    output logic        busy,
    output logic        done,
    output logic [31:0] pkt_count,
    output logic [47:0] byte_count
);

    localparam logic [13:0] LP_MIN = 14'(MIN_LEN);
    localparam logic [13:0] LP_MAX = 14'(MAX_LEN);
    localparam logic [63:0] LP_HDR0 = {DST_MAC, SRC_MAC[47:32]};
    localparam logic [63:0] LP_HDR1 = {SRC_MAC[31:0], ETHERTYPE, 16'h0000};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_GAP,
        S_FIN
    } state_t;

    state_t      r_state;
    logic [13:0] r_len;
    logic [10:0] r_nw;
    logic [10:0] r_k;
    logic [31:0] r_num;
    logic [7:0]  r_ipg;
    logic [7:0]  r_gap_cnt;
    logic [31:0] r_seq;
    logic        r_stop_seen;
    logic [63:0] r_data;
    logic        r_sop;
    logic        r_eop;
    logic [2:0]  r_mod;
    logic        r_val;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_pkt_cnt;
    logic [47:0] r_byte_cnt;

    logic [13:0] w_len;
    logic [13:0] w_len_p7;
    logic [10:0] w_nw;
    logic        w_last;
    logic        w_end;
    logic [63:0] w_raw;
    logic [63:0] w_mask;
    logic [63:0] w_word;

    // Clamp the requested length and derive the word count of a frame
    always_comb begin
        w_len = cfg_len;
        if (cfg_len < LP_MIN) begin
            w_len = LP_MIN;
        end else if (cfg_len > LP_MAX) begin
            w_len = LP_MAX;
        end
        w_len_p7 = w_len + 14'd7;
        w_nw     = w_len_p7[13:3];
    end

    // Build the current frame word, zeroing bytes beyond the frame end
    always_comb begin
        w_last = (r_k == r_nw - 11'd1);
        w_end  = ((r_num != 32'd0) && (r_pkt_cnt + 32'd1 == r_num))
                 || r_stop_seen || stop;
        if (r_k == 11'd0) begin
            w_raw = LP_HDR0;
        end else if (r_k == 11'd1) begin
            w_raw = LP_HDR1;
        end else begin
            w_raw = {r_seq, 5'd0, r_k, 2'd0, r_len};
        end
        w_mask = {64{1'b1}};
        if (w_last && (r_len[2:0] != 3'd0)) begin
            w_mask = ~({64{1'b1}} >> {r_len[2:0], 3'b000});
        end
        w_word = w_raw & w_mask;
    end

    // Run control FSM with registered transmit outputs and counters
    always_ff @(posedge clk_156) begin
        if (reset_156) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_nw        <= '0;
            r_k         <= '0;
            r_num       <= '0;
            r_ipg       <= '0;
            r_gap_cnt   <= '0;
            r_seq       <= '0;
            r_stop_seen <= 1'b0;
            r_data      <= '0;
            r_sop       <= 1'b0;
            r_eop       <= 1'b0;
            r_mod       <= '0;
            r_val       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pkt_cnt   <= '0;
            r_byte_cnt  <= '0;
        end else begin
            r_data <= '0;
            r_sop  <= 1'b0;
            r_eop  <= 1'b0;
            r_mod  <= '0;
            r_val  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_len       <= w_len;
                    r_nw        <= w_nw;
                    r_num       <= cfg_num_pkts;
                    r_ipg       <= cfg_ipg;
                    r_seq       <= '0;
                    r_pkt_cnt   <= '0;
                    r_byte_cnt  <= '0;
                    r_busy      <= 1'b1;
                    r_stop_seen <= stop;
                    r_k         <= '0;
                    r_state     <= S_SEND;
                    if (!pkt_tx_full) begin
                        r_data <= LP_HDR0;
                        r_val  <= 1'b1;
                        r_sop  <= 1'b1;
                        r_k    <= 11'd1;
                    end
                end
                S_SEND: begin
                    if (stop) begin
                        r_stop_seen <= 1'b1;
                    end
                    if (!pkt_tx_full) begin
                        r_data <= w_word;
                        r_val  <= 1'b1;
                        r_sop  <= (r_k == 11'd0);
                        if (w_last) begin
                            r_eop      <= 1'b1;
                            r_mod      <= r_len[2:0];
                            r_k        <= '0;
                            r_pkt_cnt  <= r_pkt_cnt + 32'd1;
                            r_byte_cnt <= r_byte_cnt + {34'd0, r_len};
                            r_seq      <= r_seq + 32'd1;
                            if (w_end) begin
                                r_state <= S_FIN;
                            end else if (r_ipg != 8'd0) begin
                                r_gap_cnt <= r_ipg - 8'd1;
                                r_state   <= S_GAP;
                            end
                        end else begin
                            r_k <= r_k + 11'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (stop) begin
                        r_state <= S_FIN;
                    end else if (r_gap_cnt == 8'd0) begin
                        r_state <= S_SEND;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pkt_tx_data = r_data;
    assign pkt_tx_sop  = r_sop;
    assign pkt_tx_eop  = r_eop;
    assign pkt_tx_mod  = r_mod;
    assign pkt_tx_val  = r_val;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pkt_count   = r_pkt_cnt;
    assign byte_count  = r_byte_cnt;

endmodule

// File: doc/xge_pkt_gen.md
Name: xge_pkt_gen

Overview:
- Tester traffic source directly upstream of the MAC/PCS wrapper's transmit packet interface.
- Drives pkt_tx_data/sop/eop/mod/val into the MAC and honours pkt_tx_full.
- Generates deterministic, checkable Ethernet frames (FCS excluded; the MAC appends it) with configurable length, count and inter-packet gap.
- Keeps packet and byte counters for the tester register file.

Parameters:
DST_MAC, 48'hFFFFFFFFFFFF, destination MAC placed in every frame
SRC_MAC, 48'h000A35000001, source MAC placed in every frame
ETHERTYPE, 16'h88B5, EtherType field
MIN_LEN, 60, minimum frame length in bytes (no FCS); smaller cfg_len is clamped up
MAX_LEN, 9596, maximum frame length in bytes; larger cfg_len is clamped down

Ports:
clk_156  in  1  156.25 MHz clock, shared with the MAC 156 domain
reset_156  in  1  synchronous, active-high reset
start  in  1  pulse; in IDLE, latches config and begins a run
stop  in  1  pulse; finish the current packet, then end the run
cfg_len  in  14  frame length in bytes, excluding FCS
cfg_num_pkts  in  32  packets per run; 0 = continuous until stop
cfg_ipg  in  8  idle cycles between eop and the next sop
pkt_tx_full  in  1  MAC TX FIFO almost-full
pkt_tx_data  out  64  frame word; byte 0 in [63:56]
pkt_tx_sop  out  1  first word of frame
pkt_tx_eop  out  1  last word of frame
pkt_tx_mod  out  3  valid bytes in eop word; 0 = all 8
pkt_tx_val  out  1  word valid
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
pkt_count  out  32  packets completed in current/last run
byte_count  out  48  bytes completed in current/last run

Behaviour:
- Reset: all outputs 0, FSM to IDLE, all counters and seq cleared. Reset mid-packet drops the frame at once; no eop is issued.
- All outputs are registered.
- FSM states: IDLE, LOAD, SEND, GAP, FIN.
  - IDLE: start=1 goes to LOAD; start is ignored in any other state.
  - LOAD (1 cycle):
    - L = clamp(cfg_len, MIN_LEN, MAX_LEN); NW = ceil(L/8).
    - Latch cfg_num_pkts and cfg_ipg.
    - seq, pkt_count and byte_count cleared; busy=1.
  - First word with sop=val=1 is on the outputs in the second cycle after start is sampled high.
  - SEND issues words k = 0..NW-1.
  - Advance rule: a word is presented (val=1) only in cycles following a cycle where pkt_tx_full=0. If pkt_tx_full=1, the next cycle has val=0 and k holds; no word is skipped or duplicated. The single in-flight word is absorbed by MAC FIFO headroom.
  - Word contents:
    - k=0: {DST_MAC, SRC_MAC[47:32]}
    - k=1: {SRC_MAC[31:0], ETHERTYPE, 16'h0000}
    - k>=2: {seq[31:0], k[15:0], L[15:0]}
  - Bytes past L in the eop word are forced to 0. sop and eop are never high together, since NW >= 8.
- eop word: mod = L[2:0]. At eop, pkt_count += 1, byte_count += L (both wrap), seq += 1 (wraps).
- After eop:
  - If the run ends, go to FIN. The run ends when pkt_count reaches a nonzero cfg_num_pkts, or when stop was seen at any point since the previous sop.
  - Else if cfg_ipg=0, the next sop follows in the very next valid cycle.
  - Else go to GAP for exactly cfg_ipg cycles with val=0, then SEND. GAP counts clock cycles regardless of pkt_tx_full.
- stop in IDLE/FIN is ignored. stop in GAP ends the run at once (go to FIN).
- FIN (1 cycle): done=1, busy=0, then IDLE. Counters hold until the next LOAD.
- Simultaneous stop and eop in the same cycle: the current packet counts and the run ends.
- cfg_* changes during a run have no effect until the next start.

Test Plan:
1. cfg_len=64, num=1, ipg=0, full=0 -> 8 val words.
   - sop on w0, eop+mod=0 on w7.
   - w2 = {32'h0, 16'd2, 16'd64}.
   - done pulses 1 cycle after eop; pkt_count=1, byte_count=64, busy low after.
2. cfg_len=65, num=1 -> 9 words.
   - eop mod=1; w8 = {32'h0, 16'd8, 16'd65} masked to [63:56] only, i.e. 64'h0000_0000_0000_0000.
   - byte_count=65.
3. cfg_len=20 -> clamped to 60: 8 words, mod=4, len field 60.
   - cfg_len=16000 -> clamped to 9596: 1200 words, mod=4.
4. cfg_len=64, num=3, ipg=4 -> exactly 4 val=0 cycles between each eop and next sop.
   - seq fields 0, 1, 2; pkt_count=3, byte_count=192.
5. full high 5 cycles during w3 of a 64-byte frame -> val low for 5 cycles.
   - Words resume at the next index; no gaps or repeats in k; total 8 val words.
6. num=0, stop pulsed at w4 of packet 7 -> packet 7 completes with eop, then done.
   - pkt_count=8.
   - reset_156 mid-frame -> all outputs 0 next cycle; a new start begins with seq=0.
